// File: rtl/cache_arbiter_if.sv
// Request/response bundle between the fetch and memory stages, the arbiter
// and the shared cache.
interface cache_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     i_req;
  logic [ADDRESS_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0]    i_rdata;
  logic                     i_done;
  logic                     d_req;
  logic                     d_we;
  logic [ADDRESS_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0]    d_wdata;
  logic [DATA_WIDTH-1:0]    d_rdata;
  logic                     d_done;
  logic                     c_req;
  logic                     c_we;
  logic [ADDRESS_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0]    c_wdata;
  logic [DATA_WIDTH-1:0]    c_rdata;
  logic                     c_done;
  logic                     stall_if;
  logic                     stall_mem;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, c_rdata, c_done,
    output i_rdata, i_done, d_rdata, d_done, c_req, c_we, c_addr, c_wdata,
           stall_if, stall_mem
  );

  // Environment side: requesters and cache.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, c_rdata, c_done,
    input  i_rdata, i_done, d_rdata, d_done, c_req, c_we, c_addr, c_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-requester arbiter in front of a single-ported cache. Data accesses win
// by default; an instruction fetch is forced through after STARVE_LIMIT
// consecutive data grants taken while the fetch was waiting.
module cache_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic            clk,
  input  logic            reset,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t                   state;
  logic [2:0]               starve_cnt;
  logic                     i_elig;
  logic                     d_elig;
  logic                     grant_i;
  logic                     grant_d;
  logic [2:0]               starve_next;
  logic [ADDRESS_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0]    grant_wdata;

  // Eligibility and grant decision; a requester whose done pulse is still
  // high has just been served and must not be granted again.
  always_comb begin
    i_elig  = bus.i_req & ~bus.i_done;
    d_elig  = bus.d_req & ~bus.d_done;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (d_elig && !(i_elig && (starve_cnt == LIMIT))) begin
      grant_d = 1'b1;
    end else if (i_elig) begin
      grant_i = 1'b1;
    end else begin
      grant_i = 1'b0;
    end
  end

  // Starvation counter value for a data grant: counts only while a fetch waits.
  always_comb begin
    starve_next = 3'd0;
    if (bus.i_req) begin
      starve_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 3'd1;
    end else begin
      starve_next = 3'd0;
    end
  end

  // Address/data to latch toward the cache for the winning requester.
  always_comb begin
    grant_addr  = bus.i_addr;
    grant_wdata = bus.c_wdata;
    if (grant_d) begin
      grant_addr  = bus.d_addr;
      grant_wdata = bus.d_wdata;
    end else begin
      grant_addr  = bus.i_addr;
      grant_wdata = bus.c_wdata;
    end
  end

  // Arbitration FSM with registered cache request and completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      starve_cnt  <= 3'd0;
      bus.c_req   <= 1'b0;
      bus.c_we    <= 1'b0;
      bus.c_addr  <= '0;
      bus.c_wdata <= '0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
      bus.i_done  <= 1'b0;
      bus.d_done  <= 1'b0;
    end else begin
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= BUSY_D;
            bus.c_req   <= 1'b1;
            bus.c_we    <= bus.d_we;
            bus.c_addr  <= grant_addr;
            bus.c_wdata <= grant_wdata;
            starve_cnt  <= starve_next;
          end else if (grant_i) begin
            state      <= BUSY_I;
            bus.c_req  <= 1'b1;
            bus.c_we   <= 1'b0;
            bus.c_addr <= grant_addr;
            starve_cnt <= 3'd0;
          end
        end
        BUSY_I: begin
          if (bus.c_done) begin
            state       <= IDLE;
            bus.c_req   <= 1'b0;
            bus.i_done  <= 1'b1;
            bus.i_rdata <= bus.c_rdata;
          end
        end
        BUSY_D: begin
          if (bus.c_done) begin
            state      <= IDLE;
            bus.c_req  <= 1'b0;
            bus.d_done <= 1'b1;
            if (!bus.c_we) begin
              bus.d_rdata <= bus.c_rdata;
            end
          end
        end
        default: begin
          state     <= IDLE;
          bus.c_req <= 1'b0;
        end
      endcase
    end
  end

  // Stalls follow the requests directly and release in the done cycle.
  assign bus.stall_if  = bus.i_req & ~bus.i_done;
  assign bus.stall_mem = bus.d_req & ~bus.d_done;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: expected grants are queued as requests
// are driven and checked when the arbiter raises c_req; a shadow copy of the
// read-data registers follows every completion.
module tb_cache_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  grant_t      gq[$];
  logic [31:0] sh_i;
  logic [31:0] sh_d;
  logic [7:0]  starve_pat;

  cache_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cache_arbiter #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .STARVE_LIMIT(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a scenario wedges outside a bounded wait.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_grant(input logic is_d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    grant_t g;
    g.is_d  = is_d;
    g.we    = we;
    g.addr  = addr;
    g.wdata = wdata;
    gq.push_back(g);
  endtask

  // Cache model: wait for a grant, hold it lat cycles, complete, check results.
  // Returns at the negedge of the done-pulse cycle.
  task automatic serve(input int lat, input logic [31:0] rd, input bit wiggle);
    grant_t g;
    int     waited;
    int     hi;
    waited = 0;
    while (bus.c_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.c_req !== 1'b1) begin
      check_val("grant_timeout", 64'd0, 64'd1);
      return;
    end
    if (gq.size() == 0) begin
      check_val("unexpected_grant", 64'd1, 64'd0);
      return;
    end
    g = gq.pop_front();
    check_val("c_we", bus.c_we, g.we);
    check_val("c_addr", bus.c_addr, g.addr);
    if (g.is_d) check_val("c_wdata", bus.c_wdata, g.wdata);
    hi = 1;
    while (hi < lat) begin
      if (wiggle) begin
        bus.i_addr  = $urandom;
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_we    = ~bus.d_we;
      end
      @(negedge clk);
      check_val("c_req_hold", bus.c_req, 1'b1);
      check_val("c_addr_hold", bus.c_addr, g.addr);
      check_val("c_we_hold", bus.c_we, g.we);
      check_val("early_done", {bus.i_done, bus.d_done}, 2'b00);
      hi++;
    end
    bus.c_done  = 1'b1;
    bus.c_rdata = rd;
    @(negedge clk);
    bus.c_done  = 1'b0;
    bus.c_rdata = 32'h0;
    if (!g.is_d) sh_i = rd;
    else if (!g.we) sh_d = rd;
    check_val("c_req_drop", bus.c_req, 1'b0);
    check_val("i_done", bus.i_done, !g.is_d);
    check_val("d_done", bus.d_done, g.is_d);
    check_val("i_rdata", bus.i_rdata, sh_i);
    check_val("d_rdata", bus.d_rdata, sh_d);
    check_val("stall_if", bus.stall_if, bus.i_req & g.is_d);
    check_val("stall_mem", bus.stall_mem, bus.d_req & !g.is_d);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    sh_i        = 32'h0;
    sh_d        = 32'h0;
    starve_pat  = 8'b1000_1000;
    reset       = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    bus.c_rdata = 32'h0;
    bus.c_done  = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_c_req", bus.c_req, 1'b0);
    check_val("rst_c_addr", bus.c_addr, 32'h0);
    check_val("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
    check_val("rst_done", {bus.i_done, bus.d_done}, 2'b00);
    reset = 1'b0;

    // Single fetch, 3-cycle cache latency; requester inputs scrambled while busy.
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    push_grant(1'b0, 1'b0, 32'h100, 32'h0);
    serve(3, 32'hDEAD_BEEF, 1'b1);
    bus.i_req = 1'b0;
    @(negedge clk);
    check_val("i_done_width", bus.i_done, 1'b0);
    check_val("idle_c_req", bus.c_req, 1'b0);

    // Simultaneous requests: data first, fetch right after d_done.
    bus.i_addr  = 32'h200;
    bus.d_addr  = 32'h1000;
    bus.d_we    = 1'b0;
    bus.d_wdata = 32'h0BAD_F00D;
    bus.i_req   = 1'b1;
    bus.d_req   = 1'b1;
    push_grant(1'b1, 1'b0, 32'h1000, 32'h0BAD_F00D);
    push_grant(1'b0, 1'b0, 32'h200, 32'h0);
    @(negedge clk);
    check_val("stall_if_wait", bus.stall_if, 1'b1);
    serve(2, 32'h1111_2222, 1'b0);
    bus.d_req = 1'b0;
    @(negedge clk);
    check_val("fetch_after_d", bus.c_req, 1'b1);
    check_val("fetch_after_d_we", bus.c_we, 1'b0);
    serve(1, 32'h3333_4444, 1'b0);
    bus.i_req = 1'b0;
    @(negedge clk);

    // Store: write data forwarded, d_rdata left alone.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h2004;
    bus.d_wdata = 32'h55AA;
    push_grant(1'b1, 1'b1, 32'h2004, 32'h55AA);
    serve(2, 32'hFFFF_0000, 1'b0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    check_val("store_d_rdata", bus.d_rdata, sh_d);

    // Starvation: both requesting; the fetch stage re-issues one cycle after
    // each d_done, so the fetch only wins through the starvation limit.
    bus.i_addr  = 32'h400;
    bus.d_addr  = 32'h3000;
    bus.d_wdata = 32'h0;
    for (int k = 0; k < 8; k++) begin
      if (starve_pat[k]) push_grant(1'b0, 1'b0, 32'h400, 32'h0);
      else               push_grant(1'b1, 1'b0, 32'h3000, 32'h0);
    end
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      serve(1 + (k % 3), 32'hC000_0000 + 32'(k), 1'b0);
      if (k == 7) begin
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
      end else if (!starve_pat[k]) begin
        bus.i_req = 1'b0;
        @(negedge clk);
        check_val("d_done_width", bus.d_done, 1'b0);
        bus.i_req = 1'b1;
      end
    end
    @(negedge clk);
    check_val("starve_queue_empty", 64'(gq.size()), 64'd0);

    // Spurious c_done while idle.
    @(negedge clk);
    bus.c_done  = 1'b1;
    bus.c_rdata = 32'hBADB_AD00;
    @(negedge clk);
    bus.c_done = 1'b0;
    check_val("spur_done", {bus.i_done, bus.d_done}, 2'b00);
    check_val("spur_i_rdata", bus.i_rdata, sh_i);
    check_val("spur_d_rdata", bus.d_rdata, sh_d);
    check_val("spur_c_req", bus.c_req, 1'b0);

    // Reset while a store is outstanding, then a fresh grant after release.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h5000;
    bus.d_wdata = 32'hA5A5;
    @(negedge clk);
    check_val("pre_rst_c_we", bus.c_we, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_c_req", bus.c_req, 1'b0);
    check_val("mid_rst_c_we", bus.c_we, 1'b0);
    check_val("mid_rst_c_addr", bus.c_addr, 32'h0);
    check_val("mid_rst_c_wdata", bus.c_wdata, 32'h0);
    check_val("mid_rst_i_rdata", bus.i_rdata, 32'h0);
    check_val("mid_rst_d_rdata", bus.d_rdata, 32'h0);
    check_val("mid_rst_done", {bus.i_done, bus.d_done}, 2'b00);
    sh_i = 32'h0;
    sh_d = 32'h0;
    @(negedge clk);
    check_val("rst_no_d_done", bus.d_done, 1'b0);
    reset    = 1'b0;
    bus.d_we = 1'b0;
    push_grant(1'b1, 1'b0, 32'h5000, 32'hA5A5);
    serve(2, 32'h7777_8888, 1'b0);
    bus.d_req = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
